iter_divider_16bit: RTL and testbench

//  Multi-cycle restoring divider: one quotient bit per cycle via repeated trial subtraction.

---
 rtl/iter_divider_16bit_pkg.sv | 14 +
 rtl/iter_divider_16bit_if.sv | 38 +++
 rtl/addsub_nbit.sv | 11 +
 rtl/iter_divider_16bit.sv | 151 +++++++++++++++
 tb/tb_iter_divider_16bit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/iter_divider_16bit_pkg.sv
// rtl/iter_divider_16bit_pkg.sv - shared state encoding and default width for the iterative divider
// Optional signed mode is enabled by the SIGNED_DIV_EN macro in the interface and top files.
package iter_divider_16bit_pkg;

   localparam int DIV_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      DZERO = 2'd2,
      FIN   = 2'd3
   } div_state_t;

endpackage

// File: rtl/iter_divider_16bit_if.sv
// rtl/iter_divider_16bit_if.sv - start/result bundle for the iterative divider
// SIGNED_DIV_EN adds the sgn operand-mode input.
interface iter_divider_16bit_if
   import iter_divider_16bit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             dz;
   logic             ovfl;
`ifdef SIGNED_DIV_EN
   logic             sgn;

   modport master (
      output start, dividend, divisor, sgn,
      input  busy, done, quotient, remainder, dz, ovfl
   );
   modport slave (
      input  start, dividend, divisor, sgn,
      output busy, done, quotient, remainder, dz, ovfl
   );
`else
   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, dz, ovfl
   );
   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, dz, ovfl
   );
`endif
endinterface

// File: rtl/addsub_nbit.sv
// rtl/addsub_nbit.sv - plain N-bit adder/subtractor used for trial subtraction and negation
module addsub_nbit #(
   parameter int WIDTH = 17
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] y
);
   assign y = sub ? (a - b) : (a + b);
endmodule

// File: rtl/iter_divider_16bit.sv
// rtl/iter_divider_16bit.sv - restoring divider, one quotient bit per cycle, start/done handshake
// Macro SIGNED_DIV_EN: two's complement operands selected by sgn, sign fix-up in FIN.
module iter_divider_16bit
   import iter_divider_16bit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   iter_divider_16bit_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_t       state, state_nxt;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] q_r, rem_r, dsr_r, dvd_r;
   logic             dz_r;
   logic [WIDTH-1:0] quo_res, rem_res, quo_fin, rem_fin;
   logic             dz_res;
   logic             accept;
   logic [WIDTH-1:0] dvd_mag, dsr_mag;
   logic [WIDTH:0]   shifted, trial_a, trial_b, trial_y;

   assign accept  = (state == IDLE) && bus.start;
   assign shifted = {rem_r, q_r[WIDTH-1]};

`ifdef SIGNED_DIV_EN
   logic           neg_q, neg_r, ovfl_c, ovfl_res, ovfl_fin;
   logic           dvd_neg, dsr_neg;
   logic [WIDTH:0] neg_rem_y;

   assign dvd_neg = bus.sgn & bus.dividend[WIDTH-1];
   assign dsr_neg = bus.sgn & bus.divisor[WIDTH-1];
   assign dvd_mag = dvd_neg ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
   assign dsr_mag = dsr_neg ? (~bus.divisor + WIDTH'(1)) : bus.divisor;

   // Outside CALC the trial subtractor is idle, so FIN borrows it to negate the quotient.
   assign trial_a = (state == CALC) ? shifted : '0;
   assign trial_b = (state == CALC) ? {1'b0, dsr_r} : {1'b0, q_r};

   addsub_nbit #(.WIDTH(WIDTH + 1)) u_neg_rem (
      .a   ('0),
      .b   ({1'b0, rem_r}),
      .sub (1'b1),
      .y   (neg_rem_y)
   );
`else
   assign dvd_mag = bus.dividend;
   assign dsr_mag = bus.divisor;
   assign trial_a = shifted;
   assign trial_b = {1'b0, dsr_r};
`endif

   addsub_nbit #(.WIDTH(WIDTH + 1)) u_trial (
      .a   (trial_a),
      .b   (trial_b),
      .sub (1'b1),
      .y   (trial_y)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = (bus.divisor == '0) ? DZERO : CALC;
         CALC:    if (count == LAST) state_nxt = FIN;
         DZERO:   state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      quo_fin = q_r;
      rem_fin = rem_r;
`ifdef SIGNED_DIV_EN
      ovfl_fin = 1'b0;
`endif
      if (dz_r) begin
         quo_fin = '1;
         rem_fin = dvd_r;
      end else begin
`ifdef SIGNED_DIV_EN
         if (neg_q) quo_fin = trial_y[WIDTH-1:0];
         if (neg_r) rem_fin = neg_rem_y[WIDTH-1:0];
         ovfl_fin = ovfl_c;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         q_r     <= '0;
         rem_r   <= '0;
         dsr_r   <= '0;
         dvd_r   <= '0;
         dz_r    <= 1'b0;
         quo_res <= '0;
         rem_res <= '0;
         dz_res  <= 1'b0;
`ifdef SIGNED_DIV_EN
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         ovfl_c   <= 1'b0;
         ovfl_res <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            q_r   <= dvd_mag;
            rem_r <= '0;
            dsr_r <= dsr_mag;
            dvd_r <= bus.dividend;
            count <= '0;
            dz_r  <= (bus.divisor == '0);
`ifdef SIGNED_DIV_EN
            neg_q  <= dvd_neg ^ dsr_neg;
            neg_r  <= dvd_neg;
            ovfl_c <= bus.sgn && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                      && (bus.divisor == '1);
`endif
         end else if (state == CALC) begin
            count <= count + CW'(1);
            // A borrow out of the extended subtract means the divisor did not fit.
            rem_r <= trial_y[WIDTH] ? shifted[WIDTH-1:0] : trial_y[WIDTH-1:0];
            q_r   <= {q_r[WIDTH-2:0], ~trial_y[WIDTH]};
         end else if (state == FIN) begin
            quo_res <= quo_fin;
            rem_res <= rem_fin;
            dz_res  <= dz_r;
`ifdef SIGNED_DIV_EN
            ovfl_res <= ovfl_fin;
`endif
         end
      end
   end

   assign bus.busy      = (state == CALC) || (state == DZERO);
   assign bus.done      = (state == FIN);
   assign bus.quotient  = (state == FIN) ? quo_fin : quo_res;
   assign bus.remainder = (state == FIN) ? rem_fin : rem_res;
   assign bus.dz        = (state == FIN) ? dz_r : dz_res;
`ifdef SIGNED_DIV_EN
   assign bus.ovfl      = (state == FIN) ? ovfl_fin : ovfl_res;
`else
   assign bus.ovfl      = 1'b0;
`endif

endmodule

// File: tb/tb_iter_divider_16bit.sv
// tb/tb_iter_divider_16bit.sv - self-checking bench for iter_divider_16bit with a behavioural model
module tb_iter_divider_16bit;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   int   tests_run    = 0;
   int   tests_failed = 0;

   iter_divider_16bit_if #(.WIDTH(W)) bus ();

   iter_divider_16bit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      bus.dividend = a;
      bus.divisor  = b;
`ifdef SIGNED_DIV_EN
      bus.sgn = s;
`else
      if (s) bus.dividend = a;
`endif
   endtask

   // Reference: plain integer division, truncating toward zero in signed mode.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output logic ov, output int lat);
      int sa, sb;
      dz = 1'b0;
      ov = 1'b0;
      if (b == 0) begin
         q = '1; r = a; dz = 1'b1; lat = 2;
      end else begin
         lat = W + 1;
         if (!s) begin
            q = a / b;
            r = a % b;
         end else begin
            sa = $signed(a);
            sb = $signed(b);
            if (sa == -(2 ** (W - 1)) && sb == -1) begin
               q = a; r = '0; ov = 1'b1;
            end else begin
               q = W'(sa / sb);
               r = W'(sa % sb);
            end
         end
      end
   endtask

   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input string tag);
      logic [W-1:0] eq, er;
      logic         edz, eov;
      int           elat, lat;
      model(a, b, s, eq, er, edz, eov, elat);
      set_ops(a, b, s);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      lat = 1;
      check({tag, " busy1"}, bus.busy, 1'b1);
      while (!bus.done && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, " lat"}, lat, elat);
      check({tag, " busy_at_done"}, bus.busy, 1'b0);
      check({tag, " q"}, bus.quotient, eq);
      check({tag, " r"}, bus.remainder, er);
      check({tag, " dz"}, bus.dz, edz);
      check({tag, " ovfl"}, bus.ovfl, eov);
      tick();
   endtask

   initial begin
      logic [W-1:0] ra, rb, eq, er;
      logic         rs, edz, eov;
      int           elat, cyc, ndone;
      logic [W-1:0] bb_a [4];
      logic [W-1:0] bb_b [4];

      rst = 1'b1;
      bus.start = 1'b0;
      set_ops('0, '0, 1'b0);
      repeat (3) tick();
      check("rst busy", bus.busy, 1'b0);
      check("rst done", bus.done, 1'b0);
      check("rst q", bus.quotient, 16'h0);
      check("rst r", bus.remainder, 16'h0);
      check("rst dz", bus.dz, 1'b0);
      check("rst ovfl", bus.ovfl, 1'b0);
      rst = 1'b0;
      tick();

      run_div(16'd100, 16'd7, 1'b0, "100/7");
      repeat (3) tick();
      check("hold q", bus.quotient, 16'd14);
      check("hold r", bus.remainder, 16'd2);
      run_div(16'h1234, 16'h0, 1'b0, "1234/0");
      repeat (2) tick();
      check("hold dz", bus.dz, 1'b1);
      run_div(16'hFFFF, 16'h0001, 1'b0, "ffff/1");
      run_div(16'hFFFF, 16'hFFFF, 1'b0, "ffff/ffff");
      run_div(16'h0005, 16'hFFFF, 1'b0, "5/ffff");
      run_div(16'h0000, 16'h0005, 1'b0, "0/5");

      // Start pulse during CALC must be ignored.
      set_ops(16'd200, 16'd3, 1'b0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      cyc = 1;
      repeat (4) begin tick(); cyc++; end
      set_ops(16'd9, 16'd2, 1'b0);
      bus.start = 1'b1;
      tick(); cyc++;
      bus.start = 1'b0;
      while (!bus.done && cyc < 40) begin tick(); cyc++; end
      check("midstart lat", cyc, W + 1);
      check("midstart q", bus.quotient, 16'd66);
      check("midstart r", bus.remainder, 16'd2);
      // Start in the FIN cycle is also ignored.
      set_ops(16'd50, 16'd5, 1'b0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      check("fin start ignored busy", bus.busy, 1'b0);
      check("fin start ignored q", bus.quotient, 16'd66);

      // Reset during CALC aborts without a done pulse.
      set_ops(16'd1000, 16'd3, 1'b0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort busy", bus.busy, 1'b0);
      check("abort done", bus.done, 1'b0);
      check("abort q", bus.quotient, 16'h0);
      check("abort r", bus.remainder, 16'h0);
      check("abort dz", bus.dz, 1'b0);
      ndone = 0;
      repeat (25) begin
         tick();
         if (bus.done) ndone++;
      end
      check("abort no done", ndone, 0);

`ifdef SIGNED_DIV_EN
      run_div(16'hFFF9, 16'h0002, 1'b1, "s -7/2");
      run_div(16'h8000, 16'hFFFF, 1'b1, "s min/-1");
      run_div(16'h8000, 16'h0000, 1'b1, "s min/0");
      run_div(16'h0007, 16'hFFFE, 1'b1, "s 7/-2");
`endif

      // Start held high: back-to-back operations every W+2 cycles.
      for (int k = 0; k < 4; k++) begin
         bb_a[k] = W'($urandom);
         bb_b[k] = W'($urandom_range(1, 2 ** W - 1));
      end
      set_ops(bb_a[0], bb_b[0], 1'b0);
      bus.start = 1'b1;
      tick();
      cyc = 1;
      for (int k = 0; k < 4; k++) begin
         while (!bus.done && cyc < 200) begin tick(); cyc++; end
         model(bb_a[k], bb_b[k], 1'b0, eq, er, edz, eov, elat);
         check("b2b done cycle", cyc, (W + 1) + k * (W + 2));
         check("b2b q", bus.quotient, eq);
         check("b2b r", bus.remainder, er);
         if (k < 3) set_ops(bb_a[k + 1], bb_b[k + 1], 1'b0);
         else bus.start = 1'b0;
         tick();
         cyc++;
      end
      bus.start = 1'b0;
      tick();
      check("b2b idle", bus.busy, 1'b0);

      for (int i = 0; i < 2500; i++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 7))
            0:       rb = '0;
            1:       rb = W'($urandom_range(1, 15));
            2:       rb = '1;
            default: rb = W'($urandom);
         endcase
         if ($urandom_range(0, 15) == 0) ra = '1;
`ifdef SIGNED_DIV_EN
         rs = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 31) == 0) begin ra = 16'h8000; rb = '1; end
`else
         rs = 1'b0;
`endif
         run_div(ra, rb, rs, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
